// File: rtl/stick_pwm.sv
// stick_pwm: four-channel joystick-emulation PWM stage.
// Samples the roll/pitch/yaw/throttle stick targets once per PWM period,
// slew-limits each channel's level toward its target, and drives one
// 8-bit-resolution PWM output per channel.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   roll_mag..throttle  - 8-bit stick targets (sampled at period boundary)
//   enable              - 1: track inputs, 0: ramp to safe levels
//   pwm_out[3:0]        - PWM outputs (0 roll, 1 pitch, 2 yaw, 3 throttle)
//   level_out[31:0]     - applied levels, one byte per channel
//   period_start        - one-cycle pulse on the period boundary cycle
module stick_pwm #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned MAX_STEP = 4,
  parameter int unsigned NEUTRAL  = 116,
  parameter int unsigned THR_IDLE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  roll_mag,
  input  logic [7:0]  pitch_mag,
  input  logic [7:0]  yaw_mag,
  input  logic [7:0]  throttle_mag,
  input  logic        enable,
  output logic [3:0]  pwm_out,
  output logic [31:0] level_out,
  output logic        period_start
);

  localparam int unsigned PRE_W = 16;
  localparam int unsigned LVL_W = 8;
  localparam int unsigned N_CH  = 4;

  localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [LVL_W-1:0]        STEP     = LVL_W'(MAX_STEP);
  localparam logic signed [LVL_W:0]   STEP_S   = (LVL_W+1)'(MAX_STEP);
  localparam logic [LVL_W-1:0]        NEU      = LVL_W'(NEUTRAL);
  localparam logic [LVL_W-1:0]        IDLE     = LVL_W'(THR_IDLE);
  localparam logic [LVL_W-1:0]        CNT_LAST = '1;

  logic [PRE_W-1:0]           pre_q, pre_d;
  logic [LVL_W-1:0]           cnt_q, cnt_d;
  logic [N_CH-1:0][LVL_W-1:0] level_q, level_d;
  logic [N_CH-1:0][LVL_W-1:0] tgt;
  logic [N_CH-1:0]            pwm_q, pwm_d;
  logic                       ps_q, ps_d;
  logic                       tick;
  logic                       boundary;

  // Move one step toward the target; the difference is taken as a 9-bit
  // signed value so a full-scale move never wraps.
  function automatic logic [LVL_W-1:0] slew(input logic [LVL_W-1:0] lvl,
                                            input logic [LVL_W-1:0] target);
    logic signed [LVL_W:0] d;
    d = $signed({1'b0, target}) - $signed({1'b0, lvl});
    if (d > STEP_S)       slew = lvl + STEP;
    else if (d < -STEP_S) slew = lvl - STEP;
    else                  slew = target;
  endfunction

  // Prescaler, period counter, slew update and compare next-state.
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    boundary = tick && (cnt_q == CNT_LAST);
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d    = tick ? cnt_q + LVL_W'(1) : cnt_q;

    tgt[0] = enable ? roll_mag     : NEU;
    tgt[1] = enable ? pitch_mag    : NEU;
    tgt[2] = enable ? yaw_mag      : NEU;
    tgt[3] = enable ? throttle_mag : IDLE;

    level_d = level_q;
    pwm_d   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (boundary) level_d[i] = slew(level_q[i], tgt[i]);
      pwm_d[i] = (cnt_q < level_q[i]);
    end

    // Registered look-ahead: the pulse lands exactly on the boundary cycle.
    ps_d = (pre_d == PRE_LAST) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      level_q <= {IDLE, NEU, NEU, NEU};
      pwm_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign level_out    = level_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_stick_pwm.sv
// tb_stick_pwm: directed scenarios plus randomized stimulus for stick_pwm,
// checked every cycle against a behavioural model of period/level/duty.
module tb_stick_pwm;

  localparam int P    = 1;
  localparam int STEP = 4;
  localparam int NEU  = 116;
  localparam int IDLE = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  roll_mag, pitch_mag, yaw_mag, throttle_mag;
  logic        enable;
  logic [3:0]  pwm_out;
  logic [31:0] level_out;
  logic        period_start;

  int n_cmp  = 0;
  int n_fail = 0;

  stick_pwm #(.PRESCALE(P), .MAX_STEP(STEP), .NEUTRAL(NEU), .THR_IDLE(IDLE)) dut (
    .clock(clock), .reset(reset),
    .roll_mag(roll_mag), .pitch_mag(pitch_mag), .yaw_mag(yaw_mag),
    .throttle_mag(throttle_mag), .enable(enable),
    .pwm_out(pwm_out), .level_out(level_out), .period_start(period_start)
  );

  always #5 clock = ~clock;

  // Behavioural model: time since reset determines the PWM position.
  int unsigned m_k;
  int          m_lvl [4];
  int          m_tgt [4];
  logic [3:0]  m_pwm;
  logic        m_ps;
  bit          m_valid = 0;

  function automatic int mv(input int lvl, input int tgt);
    int d;
    d = tgt - lvl;
    if (d > STEP)  return lvl + STEP;
    if (d < -STEP) return lvl - STEP;
    return tgt;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_k = 0;
      m_lvl[0] = NEU; m_lvl[1] = NEU; m_lvl[2] = NEU; m_lvl[3] = IDLE;
      m_pwm = '0;
      m_ps = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      int pos;
      pos = int'((m_k / P) % 256);
      for (int i = 0; i < 4; i++) m_pwm[i] = (pos < m_lvl[i]);
      if ((m_k % P) == P - 1 && pos == 255) begin
        m_tgt[0] = enable ? int'(roll_mag)     : NEU;
        m_tgt[1] = enable ? int'(pitch_mag)    : NEU;
        m_tgt[2] = enable ? int'(yaw_mag)      : NEU;
        m_tgt[3] = enable ? int'(throttle_mag) : IDLE;
        for (int i = 0; i < 4; i++) m_lvl[i] = mv(m_lvl[i], m_tgt[i]);
      end
      m_k++;
      m_ps = ((m_k % P) == P - 1) && (((m_k / P) % 256) == 255);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      check("level_out", level_out,
            {8'(m_lvl[3]), 8'(m_lvl[2]), 8'(m_lvl[1]), 8'(m_lvl[0])});
      check("pwm_out", {28'd0, pwm_out}, {28'd0, m_pwm});
      check("period_start", {31'd0, period_start}, {31'd0, m_ps});
    end
  end

  // Stop at the negedge of the boundary cycle (levels not yet updated).
  task automatic wait_ps();
    for (int i = 0; i < 256 * P + 40; i++) begin
      @(negedge clock);
      if (period_start) return;
    end
    check("boundary_timeout", 32'd0, 32'd1);
  endtask

  // Stop one cycle after the boundary: new levels visible, cnt = 0.
  task automatic to_boundary(input int n);
    repeat (n) begin
      wait_ps();
      @(negedge clock);
    end
  endtask

  // Counts over one full period (256*P clocks).
  task automatic window(input int ch, output int hi, output int ps);
    hi = 0; ps = 0;
    repeat (256 * P) begin
      @(negedge clock);
      if (pwm_out[ch]) hi++;
      if (period_start) ps++;
    end
  endtask

  function automatic logic [7:0] rnd_mag();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  int hi, ps;

  initial begin
    reset = 1'b1; enable = 1'b0;
    roll_mag = 8'd116; pitch_mag = 8'd116; yaw_mag = 8'd116; throttle_mag = 8'd0;

    // Reset state and duty.
    repeat (2) @(negedge clock);
    check("reset_level", level_out, 32'h00747474);
    check("reset_pwm", {28'd0, pwm_out}, 32'd0);
    check("reset_ps", {31'd0, period_start}, 32'd0);
    reset = 1'b0;
    window(0, hi, ps);
    check("duty_roll_116", 32'(hi), 32'd116);
    check("ps_per_period", 32'(ps), 32'd1);
    window(3, hi, ps);
    check("duty_thr_0", 32'(hi), 32'd0);

    // Slew up: roll to 184, throttle to 200.
    enable = 1'b1; roll_mag = 8'd184; throttle_mag = 8'd200;
    to_boundary(1);
    check("slew_b1", {24'd0, level_out[7:0]}, 32'd120);
    check("mdl_b1", 32'(m_lvl[0]), 32'd120);
    to_boundary(1);
    check("slew_b2", {24'd0, level_out[7:0]}, 32'd124);
    to_boundary(14);
    check("slew_b16", {24'd0, level_out[7:0]}, 32'd180);
    to_boundary(1);
    check("slew_b17", {24'd0, level_out[7:0]}, 32'd184);
    check("others_b17", {16'd0, level_out[23:8]}, 32'h7474);
    to_boundary(33);
    check("thr_b50", level_out, 32'hC87474B8);
    check("mdl_thr_b50", 32'(m_lvl[3]), 32'd200);

    // Failsafe: drop enable mid-period.
    repeat (100) @(negedge clock);
    enable = 1'b0;
    wait_ps();
    check("fs_hold", level_out, 32'hC87474B8);
    @(negedge clock);
    check("fs_b1_thr", {24'd0, level_out[31:24]}, 32'd196);
    check("fs_b1_roll", {24'd0, level_out[7:0]}, 32'd180);
    to_boundary(16);
    check("fs_b17_roll", {24'd0, level_out[7:0]}, 32'd116);
    to_boundary(33);
    check("fs_b50", level_out, 32'h00747474);

    // No overshoot in either direction.
    enable = 1'b1; roll_mag = 8'd118; throttle_mag = 8'd0;
    to_boundary(1);
    check("nos_up1", {24'd0, level_out[7:0]}, 32'd118);
    to_boundary(1);
    check("nos_up2", {24'd0, level_out[7:0]}, 32'd118);
    roll_mag = 8'd114;
    to_boundary(1);
    check("nos_dn1", {24'd0, level_out[7:0]}, 32'd114);
    to_boundary(1);
    check("nos_dn2", {24'd0, level_out[7:0]}, 32'd114);

    // Extremes on throttle.
    window(3, hi, ps);
    check("thr0_never_high", 32'(hi), 32'd0);
    throttle_mag = 8'd255;
    to_boundary(63);
    check("thr_b63", {24'd0, level_out[31:24]}, 32'd252);
    to_boundary(1);
    check("thr_b64", {24'd0, level_out[31:24]}, 32'd255);
    window(3, hi, ps);
    check("thr255_low1", 32'(256 - hi), 32'd1);

    // Reset mid-ramp at cnt = 100.
    roll_mag = 8'd250;
    to_boundary(9);
    check("ramp_150", {24'd0, level_out[7:0]}, 32'd150);
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_level", level_out, 32'h00747474);
    check("rst_mid_pwm", {28'd0, pwm_out}, 32'd0);
    reset = 1'b0;
    to_boundary(1);
    check("ramp_resume", {24'd0, level_out[7:0]}, 32'd120);

    // Randomized stimulus with occasional resets and enable toggles.
    repeat (40) begin
      repeat ($urandom_range(1, 300)) @(negedge clock);
      roll_mag = rnd_mag(); pitch_mag = rnd_mag();
      yaw_mag = rnd_mag(); throttle_mag = rnd_mag();
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        reset = 1'b0;
      end
    end
    repeat (300) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
